// File: rtl/data_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arb
// Brief    : NUM_CH-client round-robin arbiter in front of a synchronous RAM,
//            with post-reset clear and tagged fixed-latency read return.
//            Optional per-byte write enables: DATA_MEM_ARB_BYTE_EN_EN.
// Revision : 1.0
// ============================================================================
module data_mem_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int NUM_CH     = 4,
    parameter int RD_LATENCY = 2,
    parameter bit INIT_CLEAR = 1'b1,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH-1:0]            ch_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata,
`ifdef DATA_MEM_ARB_BYTE_EN_EN
    input  logic [NUM_CH*(DATA_WIDTH/8)-1:0] ch_be,
`endif
    output logic [NUM_CH-1:0]            ch_gnt,
    output logic                         rd_valid,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic [CH_W-1:0]              rd_ch,
    output logic                         init_done
);

    localparam int                  IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] C_DEPTH   = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [IDX_W-1:0]    C_LAST    = IDX_W'(MEM_DEPTH - 1);
    localparam logic [CH_W-1:0]     C_LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        clr_q, clr_d;
    logic [CH_W-1:0]         ptr_q, ptr_d;
    logic                    init_done_q, init_done_d;
    logic [RD_LATENCY-1:0]   pv_q, pv_d;
    logic [DATA_WIDTH-1:0]   pd_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0]   pd_d [RD_LATENCY];
    logic [CH_W-1:0]         pc_q [RD_LATENCY];
    logic [CH_W-1:0]         pc_d [RD_LATENCY];
    logic                    rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [CH_W-1:0]         rd_ch_q, rd_ch_d;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                    w_found, w_xfer, w_we, w_in_range, w_mem_we, w_init_wr;
    logic [CH_W-1:0]         w_win;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [IDX_W-1:0]        w_idx, w_mem_idx;
    logic [DATA_WIDTH-1:0]   w_wdata, w_rdata, w_mem_wdata;

    function automatic logic [CH_W-1:0] f_wrap(input logic [CH_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CH_W'(s);
    endfunction

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_found && ch_req[f_wrap(ptr_q, k)]) begin
                w_found = 1'b1;
                w_win   = f_wrap(ptr_q, k);
            end
        end
    end

    assign w_xfer     = init_done_q && !reset && w_found;
    assign ch_gnt     = w_xfer ? (NUM_CH'(1) << w_win) : '0;
    assign w_we       = ch_we[w_win];
    assign w_addr     = ch_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata    = ch_wdata[w_win*DATA_WIDTH +: DATA_WIDTH];
    assign w_in_range = {1'b0, w_addr} < C_DEPTH;
    assign w_idx      = w_addr[IDX_W-1:0];
    assign w_rdata    = w_in_range ? mem[w_idx] : '0;

    assign w_init_wr   = (state_q == ST_INIT) && !reset;
    assign w_mem_we    = w_init_wr || (w_xfer && w_we && w_in_range);
    assign w_mem_idx   = w_init_wr ? clr_q : w_idx;
    assign w_mem_wdata = w_init_wr ? '0 : w_wdata;

`ifdef DATA_MEM_ARB_BYTE_EN_EN
    localparam int BE_W = DATA_WIDTH / 8;
    logic [BE_W-1:0] w_mem_be;
    assign w_mem_be = w_init_wr ? '1 : ch_be[w_win*BE_W +: BE_W];

    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (w_mem_we && w_mem_be[b]) mem[w_mem_idx][b*8 +: 8] <= w_mem_wdata[b*8 +: 8];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (w_mem_we) mem[w_mem_idx] <= w_mem_wdata;
    end
`endif

    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        init_done_d = init_done_q;
        ptr_d       = ptr_q;
        pv_d[0]     = w_xfer && !w_we;
        pd_d[0]     = w_rdata;
        pc_d[0]     = w_win;
        for (int s = 1; s < RD_LATENCY; s++) begin
            pv_d[s] = pv_q[s-1];
            pd_d[s] = pd_q[s-1];
            pc_d[s] = pc_q[s-1];
        end
        rd_valid_d = pv_q[RD_LATENCY-1];
        rd_data_d  = rd_data_q;
        rd_ch_d    = rd_ch_q;
        if (pv_q[RD_LATENCY-1]) begin
            rd_data_d = pd_q[RD_LATENCY-1];
            rd_ch_d   = pc_q[RD_LATENCY-1];
        end
        case (state_q)
            ST_INIT: begin
                clr_d = clr_q + IDX_W'(1);
                if (clr_q == C_LAST) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                    clr_d       = '0;
                end
            end
            default: init_done_d = 1'b1;
        endcase
        if (w_xfer) ptr_d = (w_win == C_LAST_CH) ? '0 : w_win + CH_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT_CLEAR ? ST_INIT : ST_RUN;
            clr_q       <= '0;
            ptr_q       <= '0;
            init_done_q <= 1'b0;
            pv_q        <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_ch_q     <= '0;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            ptr_q       <= ptr_d;
            init_done_q <= init_done_d;
            pv_q        <= pv_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_ch_q     <= rd_ch_d;
        end
    end

    // Payload stages need no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        for (int s = 0; s < RD_LATENCY; s++) begin
            pd_q[s] <= pd_d[s];
            pc_q[s] <= pc_d[s];
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_ch     = rd_ch_q;
    assign init_done = init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arb
// Brief    : Directed self-checking bench for data_mem_arb (4 ch, 16 words).
// Revision : 1.0
// ============================================================================
module tb_data_mem_arb;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NC = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NC-1:0]   ch_req;
    logic [NC-1:0]   ch_we;
    logic [NC*AW-1:0] ch_addr;
    logic [NC*DW-1:0] ch_wdata;
`ifdef DATA_MEM_ARB_BYTE_EN_EN
    logic [NC*4-1:0] ch_be;
`endif
    logic [NC-1:0]   ch_gnt;
    logic            rd_valid;
    logic [DW-1:0]   rd_data;
    logic [1:0]      rd_ch;
    logic            init_done;

    int n_pass  = 0;
    int n_total = 0;

    data_mem_arb #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_DEPTH  (16),
        .NUM_CH     (NC),
        .RD_LATENCY (2),
        .INIT_CLEAR (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ch_req    (ch_req),
        .ch_we     (ch_we),
        .ch_addr   (ch_addr),
        .ch_wdata  (ch_wdata),
`ifdef DATA_MEM_ARB_BYTE_EN_EN
        .ch_be     (ch_be),
`endif
        .ch_gnt    (ch_gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ch     (rd_ch),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_ch(input int ch, input logic req, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] data);
        ch_req[ch]             = req;
        ch_we[ch]              = we;
        ch_addr[ch*AW +: AW]   = addr;
        ch_wdata[ch*DW +: DW]  = data;
    endtask

    // Expects rd_valid low, low, then one return pulse after a read grant edge.
    task automatic expect_read(input string tag, input logic [31:0] data, input logic [1:0] ch);
        check({tag, "_lat1"}, {31'd0, rd_valid}, 32'd0);
        step();
        check({tag, "_lat2"}, {31'd0, rd_valid}, 32'd0);
        step();
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check({tag, "_data"}, rd_data, data);
        check({tag, "_ch"}, {30'd0, rd_ch}, {30'd0, ch});
    endtask

    logic [31:0] exp_all [4];

    initial begin
        reset    = 1'b1;
        ch_req   = '0;
        ch_we    = '0;
        ch_addr  = '0;
        ch_wdata = '0;
`ifdef DATA_MEM_ARB_BYTE_EN_EN
        ch_be    = '1;
`endif
        // ch0 requests a read of addr 5 through reset and init
        set_ch(0, 1'b1, 1'b0, 10'd5, 32'd0);
        step(); step(); step();
        check("rst_gnt", {28'd0, ch_gnt}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_rd_ch", {30'd0, rd_ch}, 32'd0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);

        reset = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            settle();
            check("init_gnt", {28'd0, ch_gnt}, 32'd0);
            step();
            check("init_done_edge", {31'd0, init_done}, (c == 16) ? 32'd1 : 32'd0);
        end

        settle();
        check("first_gnt", {28'd0, ch_gnt}, 32'h1);
        step();
        set_ch(0, 1'b0, 1'b0, 10'd0, 32'd0);
        expect_read("rd_addr5", 32'h0, 2'd0);

        // RAW: ch0 writes addr 3, ch1 reads it on the next edge
        set_ch(0, 1'b1, 1'b1, 10'd3, 32'hDEADBEEF);
        settle();
        check("wr_gnt", {28'd0, ch_gnt}, 32'h1);
        step();
        set_ch(0, 1'b0, 1'b0, 10'd0, 32'd0);
        set_ch(1, 1'b1, 1'b0, 10'd3, 32'd0);
        settle();
        check("raw_gnt", {28'd0, ch_gnt}, 32'h2);
        step();
        set_ch(1, 1'b0, 1'b0, 10'd0, 32'd0);
        expect_read("raw", 32'hDEADBEEF, 2'd1);
        step();
        check("hold_valid", {31'd0, rd_valid}, 32'd0);
        check("hold_data", rd_data, 32'hDEADBEEF);

        // ch3 write brings the pointer back to 0
        set_ch(3, 1'b1, 1'b1, 10'd4, 32'hA5A50004);
        settle();
        check("ch3_wr_gnt", {28'd0, ch_gnt}, 32'h8);
        step();
        set_ch(3, 1'b0, 1'b0, 10'd0, 32'd0);

        // all four channels reading continuously
        exp_all[0] = 32'hDEADBEEF;
        exp_all[1] = 32'hA5A50004;
        exp_all[2] = 32'h0;
        exp_all[3] = 32'hDEADBEEF;
        set_ch(0, 1'b1, 1'b0, 10'd3, 32'd0);
        set_ch(1, 1'b1, 1'b0, 10'd4, 32'd0);
        set_ch(2, 1'b1, 1'b0, 10'd5, 32'd0);
        set_ch(3, 1'b1, 1'b0, 10'd3, 32'd0);
        for (int k = 0; k < 10; k++) begin
            if (k == 8) ch_req = '0;
            settle();
            check("rr_gnt", {28'd0, ch_gnt}, (k < 8) ? (32'd1 << (k % 4)) : 32'd0);
            step();
            if (k >= 2) begin
                check("rr_valid", {31'd0, rd_valid}, 32'd1);
                check("rr_ch", {30'd0, rd_ch}, 32'(k - 2) % 32'd4);
                check("rr_data", rd_data, exp_all[(k - 2) % 4]);
            end
        end
        step();
        check("rr_drain", {31'd0, rd_valid}, 32'd0);

        // two reads in flight, then reset; ch2 holds a request through it
        set_ch(0, 1'b1, 1'b0, 10'd3, 32'd0);
        set_ch(1, 1'b1, 1'b0, 10'd4, 32'd0);
        settle();
        check("fl_gnt0", {28'd0, ch_gnt}, 32'h1);
        step();
        set_ch(0, 1'b0, 1'b0, 10'd0, 32'd0);
        settle();
        check("fl_gnt1", {28'd0, ch_gnt}, 32'h2);
        step();
        set_ch(1, 1'b0, 1'b0, 10'd0, 32'd0);
        set_ch(2, 1'b1, 1'b0, 10'd3, 32'd0);
        reset = 1'b1;
        settle();
        check("fl_rst_gnt", {28'd0, ch_gnt}, 32'd0);
        step();
        check("fl_rst_valid", {31'd0, rd_valid}, 32'd0);
        check("fl_rst_init", {31'd0, init_done}, 32'd0);
        reset = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            settle();
            check("reinit_gnt", {28'd0, ch_gnt}, 32'd0);
            step();
            check("reinit_valid", {31'd0, rd_valid}, 32'd0);
            check("reinit_done", {31'd0, init_done}, (c == 16) ? 32'd1 : 32'd0);
        end
        settle();
        check("held_gnt", {28'd0, ch_gnt}, 32'h4);
        step();
        set_ch(2, 1'b0, 1'b0, 10'd0, 32'd0);
        expect_read("cleared_addr3", 32'h0, 2'd2);

        // out-of-range write then read of addr 20; alias addr 4 stays clear
        set_ch(2, 1'b1, 1'b1, 10'd20, 32'h11111111);
        settle();
        check("oor_wr_gnt", {28'd0, ch_gnt}, 32'h4);
        step();
        set_ch(2, 1'b1, 1'b0, 10'd20, 32'd0);
        settle();
        check("oor_rd_gnt", {28'd0, ch_gnt}, 32'h4);
        step();
        set_ch(2, 1'b0, 1'b0, 10'd0, 32'd0);
        expect_read("oor_rd", 32'h0, 2'd2);
        set_ch(2, 1'b1, 1'b0, 10'd4, 32'd0);
        settle();
        step();
        set_ch(2, 1'b0, 1'b0, 10'd0, 32'd0);
        expect_read("alias_addr4", 32'h0, 2'd2);

`ifdef DATA_MEM_ARB_BYTE_EN_EN
        ch_be = '1;
        set_ch(0, 1'b1, 1'b1, 10'd7, 32'hFFFFFFFF);
        settle();
        step();
        ch_be[3:0] = 4'b0101;
        set_ch(0, 1'b1, 1'b1, 10'd7, 32'h12345678);
        settle();
        step();
        ch_be = '1;
        set_ch(0, 1'b1, 1'b0, 10'd7, 32'd0);
        settle();
        step();
        set_ch(0, 1'b0, 1'b0, 10'd0, 32'd0);
        expect_read("byte_en", 32'hFF34FF78, 2'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
